// File: rtl/self_purging_voter_ctrl_if.sv
// Replica-data and health-status bundle for the self-purging voter.
interface self_purging_voter_ctrl_if #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 4
);
    logic [N*W-1:0] in;
    logic           valid_in;
    logic           clear_purge;
    logic [W-1:0]   out;
    logic           valid_out;
    logic           no_majority;
    logic [N-1:0]   active_mask;
    logic           purge_event;
    logic           fail;
    logic [1:0]     state;

    modport master (
        output in, valid_in, clear_purge,
        input  out, valid_out, no_majority, active_mask, purge_event, fail, state
    );

    modport slave (
        input  in, valid_in, clear_purge,
        output out, valid_out, no_majority, active_mask, purge_event, fail, state
    );
endinterface

// File: rtl/self_purging_voter_ctrl.sv
// Bitwise majority voter over N replicas; purges a replica after K consecutive
// disagreements with the vote, bounded below by MIN_ACTIVE survivors.
module self_purging_voter_ctrl #(
    parameter int unsigned N          = 6,
    parameter int unsigned W          = 4,
    parameter int unsigned K          = 3,
    parameter int unsigned MIN_ACTIVE = 3
) (
    input logic clk,
    input logic rst,
    self_purging_voter_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned KW = $clog2(K + 1);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    out_q;
    logic            valid_q;
    logic            nm_q;
    logic [N-1:0]    mask_q;
    logic            pe_q;
    logic            fail_q;
    logic [KW-1:0]   cnt_q [N];

    logic [CW-1:0]   act_cnt;
    logic [CW-1:0]   c1 [W];
    logic [W-1:0]    vote;
    logic            tie_any;
    logic [N-1:0]    mism;
    logic [N-1:0]    cand;
    logic [CW-1:0]   ncand;
    logic            purge_ok;
    logic            purge_blk;

    // Vote among active replicas and find replicas about to hit K mismatches
    always_comb begin
        act_cnt   = '0;
        vote      = '0;
        tie_any   = 1'b0;
        mism      = '0;
        cand      = '0;
        ncand     = '0;
        for (int unsigned b = 0; b < W; b++) c1[b] = '0;
        for (int unsigned i = 0; i < N; i++) act_cnt = act_cnt + CW'(mask_q[i]);
        for (int unsigned b = 0; b < W; b++) begin
            for (int unsigned i = 0; i < N; i++)
                if (mask_q[i]) c1[b] = c1[b] + CW'(bus.in[i*W + b]);
            if ({c1[b], 1'b0} > {1'b0, act_cnt}) vote[b] = 1'b1;
            else if ({c1[b], 1'b0} == {1'b0, act_cnt}) tie_any = 1'b1;
        end
        for (int unsigned i = 0; i < N; i++) begin
            mism[i] = mask_q[i] && (bus.in[i*W +: W] != vote);
            if (mism[i] && (cnt_q[i] >= KW'(K - 1))) begin
                cand[i] = 1'b1;
                ncand   = ncand + CW'(1);
            end
        end
        purge_ok  = (ncand != '0) && ((act_cnt - ncand) >= CW'(MIN_ACTIVE));
        purge_blk = (ncand != '0) && !purge_ok;
    end

    // Output, mask, counter and health-state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            nm_q    <= 1'b0;
            mask_q  <= '1;
            pe_q    <= 1'b0;
            fail_q  <= 1'b0;
            state_q <= ST_NORMAL;
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            valid_q <= bus.valid_in;
            pe_q    <= 1'b0;
            if (bus.valid_in) begin
                out_q <= vote;
                nm_q  <= tie_any;
            end
            if (bus.clear_purge) begin
                mask_q  <= '1;
                fail_q  <= 1'b0;
                state_q <= ST_NORMAL;
                for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
            end else if (bus.valid_in) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!mask_q[i] || !mism[i]) cnt_q[i] <= '0;
                    else if (cand[i])           cnt_q[i] <= purge_ok ? '0 : KW'(K);
                    else                        cnt_q[i] <= cnt_q[i] + KW'(1);
                end
                if (purge_ok) begin
                    mask_q <= mask_q & ~cand;
                    pe_q   <= 1'b1;
                    if (state_q == ST_NORMAL) state_q <= ST_DEGRADED;
                end
                if (purge_blk) begin
                    fail_q  <= 1'b1;
                    state_q <= ST_FAILED;
                end
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.valid_out   = valid_q;
    assign bus.no_majority = nm_q;
    assign bus.active_mask = mask_q;
    assign bus.purge_event = pe_q;
    assign bus.fail        = fail_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_self_purging_voter_ctrl.sv
// Directed and randomized checks of self_purging_voter_ctrl against a
// sample-level reference model.
module tb_self_purging_voter_ctrl;
    localparam int N    = 6;
    localparam int W    = 4;
    localparam int K    = 3;
    localparam int MINA = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    self_purging_voter_ctrl_if #(.N(N), .W(W)) bus ();

    self_purging_voter_ctrl #(.N(N), .W(W), .K(K), .MIN_ACTIVE(MINA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int rep   [N];
    int m_cnt [N];
    bit m_act [N];
    int m_out, m_state;
    bit m_vout, m_nm, m_pe, m_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_act[i];
        return m;
    endfunction

    task automatic model_reset();
        m_out = 0; m_vout = 0; m_nm = 0; m_pe = 0; m_fail = 0; m_state = 0;
        for (int i = 0; i < N; i++) begin m_act[i] = 1; m_cnt[i] = 0; end
    endtask

    // One clock edge of the specified behaviour, from replica words in rep[]
    task automatic model_step(input bit v, input bit clr);
        int a, c1, vote, ncand;
        bit tie;
        int nc [N];
        bit cand [N];
        a = 0;
        for (int i = 0; i < N; i++) a += int'(m_act[i]);
        vote = 0; tie = 0;
        for (int b = 0; b < W; b++) begin
            c1 = 0;
            for (int i = 0; i < N; i++)
                if (m_act[i] && (((rep[i] >> b) & 1) == 1)) c1++;
            if (2 * c1 > a) vote |= (1 << b);
            else if (2 * c1 == a) tie = 1;
        end
        m_vout = v;
        if (v) begin m_out = vote; m_nm = tie; end
        m_pe = 0;
        if (clr) begin
            m_fail = 0; m_state = 0;
            for (int i = 0; i < N; i++) begin m_act[i] = 1; m_cnt[i] = 0; end
        end else if (v) begin
            ncand = 0;
            for (int i = 0; i < N; i++) begin
                if (m_act[i] && rep[i] != vote) nc[i] = (m_cnt[i] + 1 > K) ? K : m_cnt[i] + 1;
                else nc[i] = 0;
                cand[i] = m_act[i] && (rep[i] != vote) && (nc[i] == K);
                if (cand[i]) ncand++;
            end
            if (ncand > 0 && a - ncand >= MINA) begin
                for (int i = 0; i < N; i++) if (cand[i]) begin m_act[i] = 0; nc[i] = 0; end
                m_pe = 1;
                if (m_state == 0) m_state = 1;
            end else if (ncand > 0) begin
                m_fail = 1;
                m_state = 2;
            end
            for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},         32'(bus.out),         32'(m_out));
        chk({tag, ".valid_out"},   32'(bus.valid_out),   32'(m_vout));
        chk({tag, ".no_majority"}, 32'(bus.no_majority), 32'(m_nm));
        chk({tag, ".active_mask"}, 32'(bus.active_mask), m_mask());
        chk({tag, ".purge_event"}, 32'(bus.purge_event), 32'(m_pe));
        chk({tag, ".fail"},        32'(bus.fail),        32'(m_fail));
        chk({tag, ".state"},       32'(bus.state),       32'(m_state));
    endtask

    task automatic step(input string tag, input bit v, input bit clr);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(rep[i]);
        bus.in          = p;
        bus.valid_in    = v;
        bus.clear_purge = clr;
        @(posedge clk);
        model_step(v, clr);
        #1;
        check_all(tag);
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < N; i++) rep[i] = val;
    endtask

    int faulty;
    initial begin
        bus.in = '0; bus.valid_in = 0; bus.clear_purge = 0;
        model_reset();
        set_all(0);
        #12;
        check_all("reset");
        @(negedge clk); rst = 0;

        // All replicas agree
        set_all(4'hA);
        step("agree", 1, 0);
        chk("agree.out_const", 32'(bus.out), 32'h0000000A);

        // Replica 2 wrong twice, right once, wrong twice: never purged
        rep[2] = 4'h5; step("intr0", 1, 0); step("intr1", 1, 0);
        rep[2] = 4'hA; step("intr2", 1, 0);
        rep[2] = 4'h5; step("intr3", 1, 0); step("intr4", 1, 0);
        rep[2] = 4'hA; step("intr5", 1, 0);
        chk("intr.mask_const", 32'(bus.active_mask), 32'h3F);

        // Replica 2 wrong for K samples: purged on the third
        rep[2] = 4'h5;
        step("p2_0", 1, 0); step("p2_1", 1, 0); step("p2_2", 1, 0);
        chk("p2.mask_const", 32'(bus.active_mask), 32'h3B);
        step("p2_idle", 0, 0);
        chk("p2.state_const", 32'(bus.state), 32'd1);

        // Purge replica 5 as well, leaving A=4
        rep[5] = 4'h3;
        step("p5_0", 1, 0); step("p5_1", 1, 0); step("p5_2", 1, 0);
        step("p5_idle", 0, 0);

        // Even split among the four survivors: every bit ties to 0
        rep[0] = 4'hF; rep[1] = 4'hF; rep[3] = 4'h0; rep[4] = 4'h0;
        rep[2] = 4'hF; rep[5] = 4'hF;
        step("tie", 1, 0);
        chk("tie.nm_const", 32'(bus.no_majority), 32'd1);

        // Replicas 0 and 1 disagree together: purge blocked by MIN_ACTIVE
        rep[0] = 4'h1; rep[1] = 4'h2;
        step("blk0", 1, 0); step("blk1", 1, 0); step("blk2", 1, 0);
        step("blk_idle", 0, 0);
        chk("blk.fail_const", 32'(bus.fail), 32'd1);

        set_all(4'h7);
        step("clear", 1, 1);
        step("clear_idle", 0, 0);

        // Async reset while replica 2's counter sits at 2
        rep[2] = 4'h0;
        step("rc0", 1, 0); step("rc1", 1, 0);
        bus.valid_in = 1;
        rst = 1; #2;
        model_reset();
        check_all("midrst");
        @(posedge clk); #1;
        check_all("midrst_edge");
        rst = 0;
        step("rc2", 1, 0); step("rc3", 1, 0);
        chk("rc.mask_const", 32'(bus.active_mask), 32'h3F);
        step("rc4", 1, 0);

        // Random phase: drifting faulty subsets, random valid and re-arm
        faulty = 0;
        for (int t = 0; t < 400; t++) begin
            int base;
            if (t % 25 == 0) faulty = $urandom_range(0, (1 << N) - 1);
            base = $urandom_range(0, 15);
            for (int i = 0; i < N; i++)
                rep[i] = (((faulty >> i) & 1) == 1 && $urandom_range(0, 9) < 8)
                         ? $urandom_range(0, 15) : base;
            step("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
